// File: rtl/spi_controller.sv
// SPI mode-0 write-only master: shifts 16-bit {rw, addr, data} frames out MSB first.
// Every pin is driven straight from a flop so nCS/SCLK/COPI never glitch.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] DivLoad   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SetupLoad = 8'(CS_SETUP - 1);
    localparam logic [7:0] HoldLoad  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GapLoad   = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_hi_q, phase_hi_d;
    logic [15:0] shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rst_sync_q;
    logic        accept;

    // Reset assertion is asynchronous; acceptance is held off until one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign req_ready = rst_sync_q && (state_q == StIdle);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        phase_hi_d = phase_hi_q;
        shreg_d    = shreg_q;
        sclk_d     = sclk_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    shreg_d = {req_write, req_addr, req_data};
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    state_d    = StShift;
                    cnt_d      = DivLoad;
                    bit_d      = 5'd15;
                    phase_hi_d = 1'b1;
                    sclk_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StShift: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (phase_hi_q) begin
                    phase_hi_d = 1'b0;
                    sclk_d     = 1'b0;
                    cnt_d      = DivLoad;
                    // Bit 0 stays on COPI through its low phase and HOLD.
                    if (bit_q != 5'd0) begin
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                end else if (bit_q == 5'd0) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    bit_d      = bit_q - 5'd1;
                    phase_hi_d = 1'b1;
                    sclk_d     = 1'b1;
                    cnt_d      = DivLoad;
                end
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                    shreg_d = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        ncs_d  = !((state_d == StSetup) || (state_d == StShift) || (state_d == StHold));
        busy_d = (state_d != StIdle);
        done_d = (state_q == StHold) && (state_d == StGap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            bit_q      <= 5'd0;
            phase_hi_q <= 1'b0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_hi_q <= phase_hi_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            ncs_q      <= ncs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign copi = shreg_q[15];
    assign ncs  = ncs_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: instance 0 at default timing, instance 1 at the fastest timing.
// A pin monitor rebuilds each frame from COPI at SCLK rises and measures nCS/SCLK timing.
module tb_spi_controller;

    localparam int DIV0 = 4, SET0 = 4, HLD0 = 4, IDL0 = 4;
    localparam int DIV1 = 2, SET1 = 1, HLD1 = 1, IDL1 = 4;
    localparam int LOW0 = SET0 + 32 * DIV0 + HLD0;
    localparam int LOW1 = SET1 + 32 * DIV1 + HLD1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid[2], req_ready[2], req_write[2];
    logic       sclk[2], copi[2], ncs[2], busy[2], done[2];
    logic [6:0] req_addr[2];
    logic [7:0] req_data[2];

    spi_controller #(.CLK_DIV(DIV0), .CS_SETUP(SET0), .CS_HOLD(HLD0), .CS_IDLE(IDL0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
        .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0]), .busy(busy[0]), .done(done[0])
    );

    spi_controller #(.CLK_DIV(DIV1), .CS_SETUP(SET1), .CS_HOLD(HLD1), .CS_IDLE(IDL1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
        .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1]), .busy(busy[1]), .done(done[1])
    );

    // ---------------- pin monitor ----------------
    int          cyc;
    bit          in_frame[2], edge_seen[2];
    bit          prev_sclk[2], prev_copi[2], prev_busy[2];
    logic [15:0] sh[2];
    int          nbits[2], low_len[2], rise_cyc[2], run_len[2];
    logic [15:0] frm[2][64];
    int          flen[2][64], fbits[2][64], nfrm[2];
    int          gaps[2][64], ngap[2];
    int          acc[2][64], nacc[2];
    int          ndone[2], unstable[2], bad_phase[2], rdy_busy[2], rdy_done[2];
    int          divp[2] = '{DIV0, DIV1};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                in_frame[i]  = 1'b0;
                edge_seen[i] = 1'b0;
                rise_cyc[i]  = -1;
            end else begin
                if (!ncs[i]) begin
                    if (!in_frame[i]) begin
                        in_frame[i]  = 1'b1;
                        low_len[i]   = 0;
                        nbits[i]     = 0;
                        sh[i]        = '0;
                        edge_seen[i] = 1'b0;
                        run_len[i]   = 0;
                        if (rise_cyc[i] >= 0 && ngap[i] < 64) begin
                            gaps[i][ngap[i]] = cyc - rise_cyc[i];
                            ngap[i]++;
                        end
                    end
                    low_len[i]++;
                    if (sclk[i] != prev_sclk[i]) begin
                        if (edge_seen[i] && run_len[i] != divp[i]) bad_phase[i]++;
                        edge_seen[i] = 1'b1;
                        run_len[i]   = 0;
                        if (sclk[i]) begin
                            sh[i] = {sh[i][14:0], copi[i]};
                            nbits[i]++;
                            if (copi[i] != prev_copi[i]) unstable[i]++;
                        end
                    end
                    run_len[i]++;
                end else if (in_frame[i]) begin
                    in_frame[i] = 1'b0;
                    rise_cyc[i] = cyc;
                    if (nfrm[i] < 64) begin
                        frm[i][nfrm[i]]   = sh[i];
                        flen[i][nfrm[i]]  = low_len[i];
                        fbits[i][nfrm[i]] = nbits[i];
                        nfrm[i]++;
                    end
                end
                if (busy[i] && !prev_busy[i] && nacc[i] < 64) begin
                    acc[i][nacc[i]] = cyc;
                    nacc[i]++;
                end
                if (done[i]) ndone[i]++;
                if (done[i] && req_ready[i]) rdy_done[i]++;
                if (busy[i] && req_ready[i]) rdy_busy[i]++;
            end
            prev_sclk[i] = sclk[i];
            prev_copi[i] = copi[i];
            prev_busy[i] = busy[i];
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp, n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
    endtask

    task automatic send(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
        bit ok;
        wait_ready(i, ok);
        check("ready_timeout", 32'(ok), 32'd1);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_data[i]  = d;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_frames(input int i, input int target);
        for (int k = 0; k < 3000 && nfrm[i] < target; k++) @(negedge clk);
        check("frame_timeout", 32'(nfrm[i] >= target), 32'd1);
    endtask

    task automatic check_frame(input int i, input int idx, input logic [15:0] exp, input int len);
        check("frame", 32'(frm[i][idx]), 32'(exp));
        check("ncs_low_len", 32'(flen[i][idx]), 32'(len));
        check("sclk_rises", 32'(fbits[i][idx]), 32'd16);
    endtask

    task automatic check_idle_pins(input int i);
        check("ncs_idle", 32'(ncs[i]), 32'd1);
        check("sclk_idle", 32'(sclk[i]), 32'd0);
        check("copi_idle", 32'(copi[i]), 32'd0);
        check("busy_idle", 32'(busy[i]), 32'd0);
        check("done_idle", 32'(done[i]), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_after_release", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1 check("ready_one_edge_later", 32'(req_ready[0]), 32'd1);
        check("ready1_one_edge_later", 32'(req_ready[1]), 32'd1);
    endtask

    typedef struct {
        logic        w;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt[6];
    logic [7:0]  regs[128];
    logic [15:0] exp_q[$];
    int          base, d0, cnt, k;
    bit          ps, ok;
    logic        rw;
    logic [6:0]  ra;
    logic [7:0]  rd;

    initial begin
        vt[0] = '{1'b1, 7'h04, 8'hA5, 16'h84A5};
        vt[1] = '{1'b1, 7'h00, 8'hF0, 16'h80F0};
        vt[2] = '{1'b1, 7'h03, 8'h3C, 16'h833C};
        vt[3] = '{1'b1, 7'h04, 8'h80, 16'h8480};
        vt[4] = '{1'b0, 7'h02, 8'hFF, 16'h02FF};
        vt[5] = '{1'b1, 7'h55, 8'hAA, 16'hD5AA};
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_data[i]  = '0;
        end
        for (int r = 0; r < 128; r++) regs[r] = 8'h00;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check_idle_pins(0);
        check_idle_pins(1);
        check("ready_in_reset", 32'(req_ready[0]), 32'd0);
        repeat (3) @(negedge clk);
        release_reset();

        // Table-driven frames; bench register model applies write frames
        base = nfrm[0];
        d0   = ndone[0];
        for (int v = 0; v < 6; v++) begin
            send(0, vt[v].w, vt[v].a, vt[v].d);
            check("busy_after_accept", 32'(busy[0]), 32'd1);
            wait_frames(0, base + v + 1);
            check_frame(0, base + v, vt[v].exp, LOW0);
            if (frm[0][base + v][15]) regs[frm[0][base + v][14:8]] = frm[0][base + v][7:0];
        end
        repeat (8) @(negedge clk);
        check("done_pulses_table", 32'(ndone[0] - d0), 32'd6);
        check_idle_pins(0);
        check("en_reg_out_7_0", 32'(regs[0]), 32'h00F0);
        check("en_reg_pwm_15_8", 32'(regs[3]), 32'h003C);
        check("pwm_duty_cycle", 32'(regs[4]), 32'h0080);
        check("en_reg_pwm_7_0", 32'(regs[2]), 32'h0000);

        // Back-to-back with req_valid held high
        base = nfrm[0];
        wait_ready(0, ok);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 7'h00;
        req_data[0]  = 8'hFF;
        @(posedge clk);
        #1;
        req_addr[0] = 7'h01;
        req_data[0] = 8'h0F;
        for (k = 0; k < 500 && busy[0]; k++) begin
            @(posedge clk);
            #1;
        end
        for (k = 0; k < 10 && !busy[0]; k++) begin
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        check("second_accept", 32'(busy[0]), 32'd1);
        wait_frames(0, base + 2);
        check_frame(0, base, 16'h80FF, LOW0);
        check_frame(0, base + 1, 16'h810F, LOW0);
        check("accept_period", 32'(acc[0][nacc[0] - 1] - acc[0][nacc[0] - 2]),
              32'(LOW0 + IDL0 + 1));
        check("ncs_high_min", 32'(gaps[0][ngap[0] - 1] >= IDL0), 32'd1);

        // Inputs scrambled while busy must not affect the in-flight frame
        base = nfrm[0];
        send(0, 1'b1, 7'h2A, 8'h5A);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            req_write[0] = 1'($urandom);
            req_addr[0]  = 7'($urandom);
            req_data[0]  = 8'($urandom);
            if (req_ready[0]) cnt++;
        end
        check("ready_while_busy", 32'(cnt), 32'd0);
        wait_frames(0, base + 1);
        check_frame(0, base, 16'hAA5A, LOW0);

        // Reset after the 5th SCLK rise
        base = nfrm[0];
        d0   = ndone[0];
        send(0, 1'b1, 7'h7F, 8'hFF);
        cnt = 0;
        ps  = sclk[0];
        for (k = 0; k < 500 && cnt < 5; k++) begin
            @(posedge clk);
            #1;
            if (sclk[0] && !ps) cnt++;
            ps = sclk[0];
        end
        check("rise_count_before_reset", 32'(cnt), 32'd5);
        check("copi_before_reset", 32'(copi[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_pins(0);
        check("ready_mid_reset", 32'(req_ready[0]), 32'd0);
        repeat (3) @(negedge clk);
        release_reset();
        repeat (4) @(negedge clk);
        check("no_done_after_reset", 32'(ndone[0] - d0), 32'd0);
        check("no_partial_frame", 32'(nfrm[0]), 32'(base));
        check("no_pending_request", 32'(busy[0]), 32'd0);

        // Randomized frames against the reference frame format
        base = nfrm[0];
        d0   = ndone[0];
        for (int n = 0; n < 12; n++) begin
            rw = 1'($urandom);
            ra = 7'($urandom);
            rd = 8'($urandom);
            exp_q.push_back({rw, ra, rd});
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, rw, ra, rd);
        end
        wait_frames(0, base + 12);
        for (int n = 0; n < 12; n++) check_frame(0, base + n, exp_q[n], LOW0);
        repeat (8) @(negedge clk);
        check("done_pulses_random", 32'(ndone[0] - d0), 32'd12);

        // Fastest timing on instance 1
        base = nfrm[1];
        d0   = ndone[1];
        send(1, 1'b1, 7'h25, 8'h3C);
        rw = 1'($urandom);
        ra = 7'($urandom);
        rd = 8'($urandom);
        send(1, rw, ra, rd);
        wait_frames(1, base + 2);
        check_frame(1, base, 16'hA53C, LOW1);
        check_frame(1, base + 1, {rw, ra, rd}, LOW1);
        repeat (8) @(negedge clk);
        check("done_pulses_fast", 32'(ndone[1] - d0), 32'd2);
        check_idle_pins(1);

        for (int i = 0; i < 2; i++) begin
            check("copi_stable_at_rise", 32'(unstable[i]), 32'd0);
            check("sclk_phase_len", 32'(bad_phase[i]), 32'd0);
            check("ready_while_busy_mon", 32'(rdy_busy[i]), 32'd0);
            check("ready_with_done", 32'(rdy_done[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI Mode-0, write-only controller that produces the 16-bit register-write frames our SPI peripheral accepts: {rw, addr[6:0], data[7:0]}, MSB first. It accepts one request per valid/ready handshake and generates nCS, SCLK and COPI from the system clock. It is used as the bench driver and as the on-chip master for chaining configuration to a downstream peripheral. Output pins are registered and glitch-free.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255. Keep at 4 or more for a peripheral with a 3-flop SCLK synchroniser.
CS_SETUP, 4, clk cycles nCS is low with SCLK low before the first rising edge; legal range 1..255.
CS_HOLD, 4, clk cycles nCS stays low after the final SCLK low phase; legal range 1..255.
CS_IDLE, 4, minimum clk cycles nCS is high between frames; legal range 2..255.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_write  input  1  frame bit 15 (1 = write)
req_addr  input  7  frame bits 14:8
req_data  input  8  frame bits 7:0
sclk  output  1  SPI clock, idles low
copi  output  1  serial data, MSB first
ncs  output  1  chip select, active low
busy  output  1  high from the cycle after accept until return to IDLE
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: async assert and sync deassert internally. Reset drives ncs=1, sclk=0, copi=0, busy=0, done=0 and req_ready=0 for the first cycle after release, then req_ready=1. The state is IDLE.
- Accept: in IDLE, req_valid && req_ready latches {req_write, req_addr, req_data} into a 16-bit shift register. Input changes after accept have no effect on the frame.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP: entered the cycle after accept. ncs=0, sclk=0, copi=frame[15]. Lasts CS_SETUP cycles.
- SHIFT: runs 16 bits, MSB to LSB. Each bit has a high phase of CLK_DIV cycles with sclk=1, then a low phase of CLK_DIV cycles with sclk=0.
  - copi changes only on the first cycle of a low phase, to the next bit, for bits 15..1.
  - After bit 0's high phase, copi holds bit 0 through the low phase.
  - A 5-bit bit counter and an 8-bit divider counter are used; there is no wrap beyond 16 bits.
- HOLD: sclk=0, ncs=0 for CS_HOLD cycles.
- GAP: ncs=1, copi=0 for CS_IDLE cycles. done pulses on the first GAP cycle. busy drops and req_ready rises on the cycle after the last GAP cycle.
- Frame timing: nCS is low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (136 at defaults). Exactly 16 rising SCLK edges occur per frame. The minimum accept-to-accept period is that value + CS_IDLE + 1.
- Back-to-back: if req_valid stays high, the next request is accepted on the first IDLE cycle. nCS high time is never less than CS_IDLE.
- req_write=0 frames are transmitted identically. The controller does not block them; the peripheral ignores them.
- Reset mid-frame immediately forces the idle pin levels. The partial frame is discarded, no done pulse is produced, and no pending request is retained.
- done and req_ready are never high in the same cycle.

Test Plan:
- Reset, then one request write=1, addr=0x04, data=0xA5 -> COPI sampled at SCLK rising edges reads 0x84A5. nCS low for 136 cycles, 16 rising edges, one done pulse, ncs=1 afterwards.
- req_valid held high with two requests, 0x00/0xFF then 0x01/0x0F -> second accept occurs only in IDLE. nCS high for at least 4 cycles between frames. Frames read 0x80FF and 0x810F.
- Change req_addr/req_data while busy -> the in-flight frame is unchanged, and req_ready stays 0 until the frame completes.
- Loopback to the SPI peripheral with writes 0x00=0xF0, 0x03=0x3C, 0x04=0x80, then a write=0 frame to 0x02=0xFF -> en_reg_out_7_0=0xF0, en_reg_pwm_15_8=0x3C, pwm_duty_cycle=0x80, and en_reg_pwm_7_0 stays 0x00.
- Assert rst_n low after the 5th SCLK rising edge -> ncs=1, sclk=0, copi=0 in the same cycle, no done pulse. A following full request transmits correctly.
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=1 -> nCS low for 66 cycles. Each SCLK high and low phase is 2 cycles, and COPI is stable across every rising edge.
